aes_stream_bridge: RTL and testbench



---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_word_serializer.sv | 79 +++++++
 rtl/aes_stream_bridge.sv | 117 +++++++++++
 tb/tb_aes_stream_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block/key widths and the bridge state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    // Bridge sequencing states; the encoding is shared with aes_cipher.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } aes_state_e;

    // Number of stream words that make up one 128-bit block.
    function automatic int words_per_block(input int word_w);
        return AES_BLOCK_W / word_w;
    endfunction

endpackage

// File: rtl/aes_word_serializer.sv
// Captures a 128-bit ciphertext block and emits it as WORD_W words, MSB word first.
// Latency: load_i in cycle N gives out_valid with word 0 in cycle N+1.
// Backpressure: out_word/out_valid/out_last hold while out_ready is low.
`timescale 1ns/1ps
module aes_word_serializer
    import aes_pkg::*;
#(
    parameter int WORD_W = 32
)
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   load_i,
    input  logic [AES_BLOCK_W-1:0] data_i,
    output logic [WORD_W-1:0]      out_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   drained_o
);

    localparam int NWORDS = words_per_block(WORD_W);
    localparam int CW     = $clog2(NWORDS);
    localparam logic [CW-1:0] K_LAST = CW'(NWORDS - 1);
    localparam logic [CW-1:0] K_PEN  = CW'(NWORDS - 2);

    logic [AES_BLOCK_W-1:0] buf_q, buf_d;
    logic [CW-1:0]          k_q, k_d;
    logic                   vld_q, vld_d;
    logic                   last_q, last_d;
    logic                   hs;

    assign hs        = vld_q & out_ready;
    assign drained_o = hs & (k_q == K_LAST);

    // The buffer shifts left one word per handshake so the current word is always on top.
    always_comb begin
        buf_d  = buf_q;
        k_d    = k_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (load_i) begin
            buf_d  = data_i;
            k_d    = '0;
            vld_d  = 1'b1;
            last_d = 1'b0;
        end else if (hs) begin
            buf_d = {buf_q[AES_BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
            if (k_q == K_LAST) begin
                k_d    = '0;
                vld_d  = 1'b0;
                last_d = 1'b0;
            end else begin
                k_d    = k_q + 1'b1;
                last_d = (k_q == K_PEN);
            end
        end
    end

    // Register the buffer, word index and output qualifiers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q  <= '0;
            k_q    <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            k_q    <= k_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign out_word  = buf_q[AES_BLOCK_W-1 -: WORD_W];
    assign out_valid = vld_q;
    assign out_last  = last_q;

endmodule

// File: rtl/aes_stream_bridge.sv
// Word-serial front/back end for aes_cipher: packs plaintext, starts the core, streams ciphertext.
// Latency: last input handshake in cycle N gives aes_start in N+1; aes_done gives out_valid next cycle.
// Backpressure: in_ready only in FILL (no fill/drain overlap); output stalls on out_ready low.
`timescale 1ns/1ps
module aes_stream_bridge
    import aes_pkg::*;
#(
    parameter int WORD_W = 32
)
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [WORD_W-1:0]      in_word,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_KEY_W-1:0]   key_in,
    input  logic                   key_load,
    output logic                   busy,
    output logic [AES_BLOCK_W-1:0] aes_plain_text,
    output logic [AES_KEY_W-1:0]   aes_key,
    output logic                   aes_start,
    input  logic [AES_BLOCK_W-1:0] aes_cipher_text,
    input  logic                   aes_done,
    output logic [WORD_W-1:0]      out_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int NWORDS = words_per_block(WORD_W);
    localparam int CW     = $clog2(NWORDS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NWORDS - 1);

    aes_state_e             state_q;
    logic [CW-1:0]          cnt_q;
    logic [AES_BLOCK_W-1:0] pt_q;
    logic [AES_KEY_W-1:0]   key_q;
    logic                   start_q;
    logic                   busy_q;
    logic                   capture;
    logic                   drained;

    assign in_ready = (state_q == FILL);

    // aes_done only matters while a block is in flight.
    assign capture = (state_q == WAIT) & aes_done;

    // Block sequencer: packs words, pulses start, waits for done, waits for the drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pt_q    <= '0;
            key_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    // Key may only change between blocks, before any word is taken.
                    if (key_load && (cnt_q == '0)) begin
                        key_q <= key_in;
                    end
                    if (in_valid) begin
                        pt_q   <= {pt_q[AES_BLOCK_W-WORD_W-1:0], in_word};
                        busy_q <= 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            start_q <= 1'b1;
                            state_q <= START;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (aes_done) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        busy_q  <= 1'b0;
                        state_q <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign aes_plain_text = pt_q;
    assign aes_key        = key_q;
    assign aes_start      = start_q;
    assign busy           = busy_q;

    aes_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (capture),
        .data_i    (aes_cipher_text),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .drained_o (drained)
    );

endmodule

// File: tb/tb_aes_stream_bridge.sv
// Directed bench for aes_stream_bridge with a stub AES core (FIPS-197 C.1 vector, else pt^key).
// Latency: stub raises done four cycles after sampling start.
// Backpressure: exercised on output word 2.
`timescale 1ns/1ps
module tb_aes_stream_bridge;
    import aes_pkg::*;

    localparam int WORD_W = 32;
    localparam int NW     = 128 / WORD_W;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] CT2  = 128'h01326754cdfeab9889baefdc45762310;
    localparam logic [127:0] KFF  = {128{1'b1}};
    localparam logic [127:0] SPUR = 128'hdeadbeefcafef00d0badc0de12345678;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [WORD_W-1:0] in_word = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [127:0]      key_in = '0;
    logic              key_load = 1'b0;
    logic              busy;
    logic [127:0]      aes_plain_text;
    logic [127:0]      aes_key;
    logic              aes_start;
    logic [127:0]      aes_cipher_text;
    logic              aes_done;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;

    logic              done_spur = 1'b0;
    logic              m_done = 1'b0;
    logic [127:0]      m_ct = '0;
    int                m_cnt = 0;
    int                done_cnt = 0;
    int                checks = 0;
    int                failures = 0;
    int                done0;

    always #5 clk = ~clk;

    aes_stream_bridge #(.WORD_W(WORD_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .in_word         (in_word),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .key_in          (key_in),
        .key_load        (key_load),
        .busy            (busy),
        .aes_plain_text  (aes_plain_text),
        .aes_key         (aes_key),
        .aes_start       (aes_start),
        .aes_cipher_text (aes_cipher_text),
        .aes_done        (aes_done),
        .out_word        (out_word),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last)
    );

    assign aes_done        = m_done | done_spur;
    assign aes_cipher_text = done_spur ? SPUR : m_ct;

    function automatic logic [127:0] stub_cipher(input logic [127:0] p, input logic [127:0] k);
        if (p == PT1 && k == KEY1) return CT1;
        return p ^ k;
    endfunction

    // Stub core: samples start on the falling edge, answers with a one-cycle done later.
    always @(negedge clk) begin
        m_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_done   = 1'b1;
                done_cnt = done_cnt + 1;
            end
        end
        if (aes_start) begin
            m_ct  = stub_cipher(aes_plain_text, aes_key);
            m_cnt = 4;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Feed one block; returns on the cycle after the start pulse (core busy).
    task automatic send_block(input logic [127:0] pt, input bit gap, input bit spur, input bit kl_mid);
        for (int i = 0; i < NW; i++) begin
            in_word  = pt[127-WORD_W*i -: WORD_W];
            in_valid = 1'b1;
            if (kl_mid && i == 1) begin
                key_in   = KFF;
                key_load = 1'b1;
            end
            check_val("in_ready_fill", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            key_load = 1'b0;
            if (i == 0) check_val("busy_fill", busy, 1);
            if (gap && i < NW-1) begin
                if (spur && i == 1) done_spur = 1'b1;
                @(negedge clk);
                done_spur = 1'b0;
                if (spur && i == 1) begin
                    check_val("spur_fill_ready", in_ready, 1);
                    check_val("spur_fill_vld", out_valid, 0);
                end
            end
        end
        check_val("start_lat", aes_start, 1);
        @(negedge clk);
        check_val("start_pulse", aes_start, 0);
    endtask

    // Collect one block, optionally stalling word bp_k for five cycles.
    task automatic recv_block(input logic [127:0] exp, input int bp_k, input bit spur);
        int t;
        out_ready = 1'b1;
        for (int k = 0; k < NW; k++) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                check_val("timeout_out_valid", out_valid, 1);
                out_ready = 1'b0;
                return;
            end
            if (k == bp_k) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    if (spur && c == 1) done_spur = 1'b1;
                    @(negedge clk);
                    done_spur = 1'b0;
                    check_val("bp_hold_word", out_word, exp[127-WORD_W*k -: WORD_W]);
                    check_val("bp_hold_vld", out_valid, 1);
                end
                out_ready = 1'b1;
            end
            check_val($sformatf("word%0d", k), out_word, exp[127-WORD_W*k -: WORD_W]);
            check_val($sformatf("last%0d", k), out_last, (k == NW-1));
            check_val("in_ready_drain", in_ready, 0);
            check_val("busy_drain", busy, 1);
            @(negedge clk);
        end
        check_val("in_ready_after", in_ready, 1);
        check_val("vld_after", out_valid, 0);
        check_val("last_after", out_last, 0);
        check_val("busy_after", busy, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_start", aes_start, 0);
        check_val("rst_vld", out_valid, 0);
        check_val("rst_last", out_last, 0);
        check_val("rst_word", out_word, 0);
        check_val("rst_pt", aes_plain_text, 0);
        check_val("rst_key", aes_key, 0);
        rstn = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);

        // Straight FIPS-197 C.1 block.
        load_key(KEY1);
        check_val("key1_loaded", aes_key, KEY1);
        check_val("busy_idle", busy, 0);
        send_block(PT1, 0, 0, 0);
        check_val("pt_held", aes_plain_text, PT1);
        recv_block(CT1, -1, 0);

        // Gapped input with a stray done while filling.
        send_block(PT1, 1, 1, 0);
        recv_block(CT1, -1, 0);

        // Backpressure on word 2 with a stray done while draining.
        send_block(PT1, 0, 0, 0);
        recv_block(CT1, 2, 1);

        // Key loads mid-fill and during WAIT are ignored.
        send_block(PT1, 0, 0, 1);
        load_key(KFF);
        check_val("key_protect", aes_key, KEY1);
        recv_block(CT1, -1, 0);

        // New key at count 0 is used for the next block.
        load_key(KEY2);
        check_val("key2_loaded", aes_key, KEY2);
        send_block(PT1, 0, 0, 0);
        recv_block(CT2, -1, 0);

        // Reset during WAIT, then the stale done must be ignored.
        load_key(KEY1);
        send_block(PT1, 0, 0, 0);
        #1 rstn = 1'b0;
        #0.1;
        done0 = done_cnt;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_vld", out_valid, 0);
        check_val("mid_rst_word", out_word, 0);
        check_val("mid_rst_pt", aes_plain_text, 0);
        check_val("mid_rst_key", aes_key, 0);
        check_val("mid_rst_start", aes_start, 0);
        #0.2 rstn = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", in_ready, 1);
        check_val("post_rst_busy", busy, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_val("stale_done_vld", out_valid, 0);
            check_val("stale_done_ready", in_ready, 1);
        end
        check_val("stale_done_seen", (done_cnt > done0), 1);

        // Two back-to-back blocks after recovery; key persists.
        load_key(KEY1);
        send_block(PT1, 0, 0, 0);
        recv_block(CT1, -1, 0);
        send_block(PT1, 0, 0, 0);
        recv_block(CT1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
